pixel_stream_fifo: RTL and testbench
====================================

PIXEL_STREAM_FIFO -- requirements
Module: pixel_stream_fifo

Interface
REQ-001 SHALL provide parameters: DATA_W, 8, pixel/feature width in bits; DEPTH, 1024, entries, power of two >= 4; AF_THRESH, 84, fill level at which CNN processing may start (3 rows x 28 px).
REQ-002 SHALL provide ports (clock and reset first): i_sys_clk  in  1  sole clock, all logic rising-edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_flush  in  1  synchronous frame flush.
REQ-005 i_wr_en  in  1  write request; i_wr_data  in  DATA_W  write word.
REQ-006 i_rd_en  in  1  read/pop request; o_rd_data  out  DATA_W  head word, first-word-fall-through.
REQ-007 o_valid  out  1  head word present (not-empty); o_full  out  1  count == DEPTH.
REQ-008 o_almost_full  out  1  count >= AF_THRESH; o_count  out  $clog2(DEPTH)+1  stored words, including the output register.
REQ-009 o_overflow  out  1  and o_underflow  out  1  sticky error flags, present only per REQ-025.

Function
REQ-010 Write accepted iff i_wr_en && !o_full && !i_flush; the read state of the same cycle has no effect on this decision.
REQ-011 Read accepted iff i_rd_en && o_valid && !i_flush; pops the head word; the next word appears on o_rd_data in the following cycle.
REQ-012 FWFT latency: word accepted at edge k into an empty FIFO -> o_valid=1, o_rd_data=word after edge k+1.
REQ-013 o_rd_data stable while o_valid=1 and no read accepted; value don't-care while o_valid=0.
REQ-014 o_count: +1 on accepted write only, -1 on accepted read only, unchanged on both; never exceeds DEPTH and never goes below 0.
REQ-015 o_full, o_almost_full, o_valid registered and consistent with o_count in the same cycle.
REQ-016 Write while full -> dropped, no state change (overflow event); read while empty -> ignored (underflow event).
REQ-017 Simultaneous write and read at count 0 -> write accepted, read ignored, underflow event.
REQ-018 Simultaneous write and read at count 1 -> both accepted, count stays 1, o_valid stays 1, new word at head next cycle.
REQ-019 Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no data loss or reorder across the wrap.
REQ-020 Flush: pointers, count, o_valid, o_full, o_almost_full cleared at next edge; flush takes priority over same-cycle wr/rd (both dropped); sticky flags are not cleared.
REQ-021 Data ordering strictly FIFO; no word is duplicated or lost except by overflow drop or flush.

Reset
REQ-022 On i_rst=1 at an edge: o_valid=0, o_full=0, o_almost_full=0, o_count=0, pointers=0, o_overflow=0, o_underflow=0; RAM contents are not cleared.
REQ-023 Reset mid-stream discards all content; the first write after deassertion follows REQ-012.
REQ-024 i_rst has priority over i_flush, i_wr_en and i_rd_en.

Configuration
REQ-025 Macro PIXEL_STREAM_FIFO_ERR_EN defined: o_overflow/o_underflow exist, set on the events of REQ-016/017 and held until i_rst.
REQ-026 Macro not defined: both ports and their logic are absent; overflow/underflow events are silently ignored; all other behaviour is identical.

Structure
REQ-027 Package cnn_pkg SHALL hold PIXEL_W (=8) and the default DEPTH/AF_THRESH constants; parameter defaults reference it.
REQ-028 Storage SHALL be a sub-module pixel_fifo_ram: simple dual-port, one clock, registered read, inferable as block RAM.
REQ-029 Elaboration SHALL fail if DEPTH is not a power of two, DEPTH < 4, or AF_THRESH is outside 1..DEPTH.

Verification
REQ-030 Reset, then write 0x11,0x22,0x33 on back-to-back cycles, no reads -> o_valid=1 two edges after the first write, o_rd_data=0x11, o_count=3.
REQ-031 DEPTH=8, AF_THRESH=6: write 8 words -> o_almost_full=1 at count 6, o_full=1 at count 8; 9th write dropped, o_overflow=1 (ERR_EN), o_count=8.
REQ-032 DEPTH=8: 20 interleaved write/read cycles with the counter pattern 0..19 -> read sequence 0..19 exact across pointer wrap.
REQ-033 Empty FIFO, wr_en=rd_en=1 with 0xA5 -> o_count=1, o_rd_data=0xA5 after latency, o_underflow=1; at count 1, wr+rd -> count stays 1.
REQ-034 Count 5, assert i_flush together with wr_en and rd_en -> o_count=0, o_valid=0 next edge, o_overflow unchanged; then i_rst -> all flags 0.
REQ-035 Build without PIXEL_STREAM_FIFO_ERR_EN -> elaborates without error ports; REQ-030..032 pass unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants: pixel width and pixel FIFO defaults.
package cnn_pkg;

    localparam int unsigned PIXEL_W        = 8;
    localparam int unsigned FIFO_DEPTH     = 1024;
    localparam int unsigned FIFO_AF_THRESH = 84;   // 3 rows x 28 px

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port single-clock RAM with registered, enabled read (block-RAM style).
module pixel_fifo_ram #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read register only updates on re_i so the head word holds between pops.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_stream_fifo.sv
// First-word-fall-through pixel FIFO feeding the CNN line buffers.
// Define PIXEL_STREAM_FIFO_ERR_EN to add sticky o_overflow/o_underflow flags.
module pixel_stream_fifo
    import cnn_pkg::*;
#(
    parameter  int unsigned DATA_W    = PIXEL_W,
    parameter  int unsigned DEPTH     = FIFO_DEPTH,
    parameter  int unsigned AF_THRESH = FIFO_AF_THRESH,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [CW-1:0]     o_count
`ifdef PIXEL_STREAM_FIFO_ERR_EN
    ,
    output logic              o_overflow,
    output logic              o_underflow
`endif
);

    if (!is_pow2(DEPTH) || DEPTH < 4 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
        $error("pixel_stream_fifo: DEPTH must be a power of two >= 4 and AF_THRESH in 1..DEPTH");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d, full_q, full_d, af_q, af_d;
    logic              sel_byp_q, sel_byp_d;
    logic [DATA_W-1:0] byp_q, byp_d, ram_rdata;
    logic              wr_acc, rd_acc, ram_pend, fetch, bypass;

    // Head word lives in the RAM read register, or in the bypass register when a
    // write refills a FIFO whose only word is being popped in the same cycle.
    always_comb begin
        wr_acc   = i_wr_en && !full_q && !i_flush;
        rd_acc   = i_rd_en && valid_q && !i_flush;
        ram_pend = count_q > CW'(valid_q);
        fetch    = !i_flush && ram_pend && (!valid_q || rd_acc);
        bypass   = rd_acc && wr_acc && !ram_pend;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        valid_d   = valid_q;
        sel_byp_d = sel_byp_q;
        byp_d     = byp_q;

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(wr_acc);
            rd_ptr_d = rd_ptr_q + AW'(fetch || bypass);
            count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
            if (fetch) begin
                valid_d   = 1'b1;
                sel_byp_d = 1'b0;
            end else if (bypass) begin
                valid_d   = 1'b1;
                sel_byp_d = 1'b1;
                byp_d     = i_wr_data;
            end else if (rd_acc) begin
                valid_d = 1'b0;
            end
        end

        full_d = (count_d == CW'(DEPTH));
        af_d   = (count_d >= CW'(AF_THRESH));
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            sel_byp_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            af_q      <= af_d;
            sel_byp_q <= sel_byp_d;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        byp_q <= byp_d;
    end

    pixel_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (i_sys_clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_wr_data),
        .re_i    (fetch),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign o_rd_data     = sel_byp_q ? byp_q : ram_rdata;
    assign o_valid       = valid_q;
    assign o_full        = full_q;
    assign o_almost_full = af_q;
    assign o_count       = count_q;

`ifdef PIXEL_STREAM_FIFO_ERR_EN
    logic ovf_q, unf_q;

    // Sticky until reset; a flush masks both events and does not clear them.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (i_wr_en && full_q && !i_flush) begin
                ovf_q <= 1'b1;
            end
            if (i_rd_en && !valid_q && !i_flush) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
`endif

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Scoreboard bench for pixel_stream_fifo at DEPTH=8, AF_THRESH=6.
module tb_pixel_stream_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEP   = 8;
    localparam int unsigned AFT   = 6;
    localparam int unsigned CNT_W = $clog2(DEP) + 1;

    logic             clk = 1'b0;
    logic             rst, flush, wr_en, rd_en;
    logic [DW-1:0]    wr_data;
    logic [DW-1:0]    rd_data;
    logic             valid, full, afull;
    logic [CNT_W-1:0] count;
`ifdef PIXEL_STREAM_FIFO_ERR_EN
    logic             ovf, unf;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];

    always #5 clk = ~clk;

    pixel_stream_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .AF_THRESH (AFT)
    ) dut (
        .i_sys_clk     (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .i_rd_en       (rd_en),
        .o_rd_data     (rd_data),
        .o_valid       (valid),
        .o_full        (full),
        .o_almost_full (afull),
        .o_count       (count)
`ifdef PIXEL_STREAM_FIFO_ERR_EN
        ,
        .o_overflow    (ovf),
        .o_underflow   (unf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
        tick();
        idle();
        rst = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (full  !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", afull); end
        checks++; if (count !== '0)   begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
`ifdef PIXEL_STREAM_FIFO_ERR_EN
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", ovf, unf); end
`endif
        sb.delete();
    endtask

    task automatic test_fwft();
        logic [DW-1:0] exp;
        int n;
        do_reset();
        wr_en = 1'b1; wr_data = 8'h11; sb.push_back(8'h11);
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fwft_latency_valid got %b exp 0", valid); end
        checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL fwft_count1 got %0d exp 1", count); end
        wr_data = 8'h22; sb.push_back(8'h22);
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fwft_valid got %b exp 1", valid); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fwft_head got %h exp 11", rd_data); end
        wr_data = 8'h33; sb.push_back(8'h33);
        tick();
        wr_en = 1'b0;
        checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL fwft_count3 got %0d exp 3", count); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fwft_head_hold got %h exp 11", rd_data); end
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            rd_en = valid;
            if (valid) begin
                exp = sb.pop_front();
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL fwft_order got %h exp %h", rd_data, exp); end
            end
            tick();
            n++;
        end
        rd_en = 1'b0;
        checks++; if (sb.size() != 0 || count !== '0) begin errors++; $display("FAIL fwft_drain left %0d count %0d exp 0", sb.size(), count); end
    endtask

    task automatic test_full();
        logic [DW-1:0] exp;
        int n;
        do_reset();
        for (int i = 0; i < int'(DEP); i++) begin
            wr_en = 1'b1; wr_data = DW'(8'h40 + i); sb.push_back(DW'(8'h40 + i));
            tick();
            checks++; if (count !== CNT_W'(i + 1)) begin errors++; $display("FAIL full_count got %0d exp %0d", count, i + 1); end
            checks++; if (afull !== ((i + 1) >= int'(AFT))) begin errors++; $display("FAIL full_afull at %0d got %b", i + 1, afull); end
            checks++; if (full !== ((i + 1) == int'(DEP))) begin errors++; $display("FAIL full_full at %0d got %b", i + 1, full); end
        end
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        checks++; if (count !== CNT_W'(DEP) || full !== 1'b1) begin errors++; $display("FAIL full_drop count %0d full %b exp 8 1", count, full); end
`ifdef PIXEL_STREAM_FIFO_ERR_EN
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_overflow got %b exp 1", ovf); end
`endif
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            rd_en = valid;
            if (valid) begin
                exp = sb.pop_front();
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL full_order got %h exp %h", rd_data, exp); end
            end
            tick();
            n++;
        end
        rd_en = 1'b0;
        checks++; if (sb.size() != 0 || count !== '0) begin errors++; $display("FAIL full_drain left %0d count %0d exp 0", sb.size(), count); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp;
        int n, nread;
        do_reset();
        nread = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = DW'(i); sb.push_back(DW'(i));
            rd_en = (i >= 3) && valid;
            if (rd_en) begin
                exp = sb.pop_front();
                nread++;
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL wrap_order got %h exp %h", rd_data, exp); end
            end
            tick();
        end
        wr_en = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            rd_en = valid;
            if (valid) begin
                exp = sb.pop_front();
                nread++;
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL wrap_order got %h exp %h", rd_data, exp); end
            end
            tick();
            n++;
        end
        rd_en = 1'b0;
        checks++; if (nread != 20 || count !== '0) begin errors++; $display("FAIL wrap_total read %0d count %0d exp 20 0", nread, count); end
    endtask

    task automatic test_simul();
        do_reset();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5;
        tick();
        idle();
        checks++; if (count !== CNT_W'(1) || valid !== 1'b0) begin errors++; $display("FAIL simul_empty count %0d valid %b exp 1 0", count, valid); end
`ifdef PIXEL_STREAM_FIFO_ERR_EN
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL simul_underflow got %b exp 1", unf); end
`endif
        tick();
        checks++; if (valid !== 1'b1 || rd_data !== 8'hA5) begin errors++; $display("FAIL simul_head valid %b data %h exp 1 a5", valid, rd_data); end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
        tick();
        idle();
        checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL simul_count1 got %0d exp 1", count); end
        checks++; if (valid !== 1'b1 || rd_data !== 8'h5A) begin errors++; $display("FAIL simul_refill valid %b data %h exp 1 5a", valid, rd_data); end
    endtask

    task automatic test_flush();
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = DW'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        checks++; if (count !== CNT_W'(5)) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
        tick();
        idle();
        checks++; if (count !== '0 || valid !== 1'b0) begin errors++; $display("FAIL flush_clear count %0d valid %b exp 0 0", count, valid); end
        checks++; if (full !== 1'b0 || afull !== 1'b0) begin errors++; $display("FAIL flush_flags full %b afull %b exp 0 0", full, afull); end
`ifdef PIXEL_STREAM_FIFO_ERR_EN
        checks++; if (unf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL flush_sticky ovf %b unf %b exp 0 1", ovf, unf); end
`endif
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_post_latency got %b exp 0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || rd_data !== 8'h77) begin errors++; $display("FAIL flush_post_head valid %b data %h exp 1 77", valid, rd_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (valid !== 1'b0 || count !== '0 || full !== 1'b0 || afull !== 1'b0) begin
            errors++; $display("FAIL flush_reset valid %b count %0d full %b afull %b exp all 0", valid, count, full, afull);
        end
`ifdef PIXEL_STREAM_FIFO_ERR_EN
        checks++; if (unf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL flush_reset_flags ovf %b unf %b exp 0 0", ovf, unf); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_data = '0;
        idle();
        test_reset();
        test_fwft();
        test_full();
        test_wrap();
        test_simul();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
